// File: rtl/out_port_arbiter_pkg.sv
// Shared constants, state encoding and a small helper for the output-port allocator.
// PORT-wide one-hot constants are reused by the flit mux and the routing logic.
package out_port_arbiter_pkg;

  localparam int PORT          = 5;
  localparam int VCH_WIDTH_NUM = 2;
  localparam int VCH_NUM       = 4;
  localparam int CREDIT_DEPTH  = 4;

  localparam logic [PORT-1:0] PORT_OH_0 = 5'b00001;
  localparam logic [PORT-1:0] PORT_OH_1 = 5'b00010;
  localparam logic [PORT-1:0] PORT_OH_2 = 5'b00100;
  localparam logic [PORT-1:0] PORT_OH_3 = 5'b01000;
  localparam logic [PORT-1:0] PORT_OH_4 = 5'b10000;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Index of the lowest set bit of a one-hot vector; 0 when empty.
  function automatic int unsigned oh_index(input logic [31:0] oh);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (oh[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/out_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr,
// wrapping from N-1 to 0. Returns a one-hot grant, zero when nothing requests.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!found && (idx < N) && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port switch allocator: round-robin packet-level grant held head to tail,
// flit transfer gated by per-VC downstream credit counters.
module out_port_arbiter
  import out_port_arbiter_pkg::*;
#(
  parameter int NUM_PORT      = 5,
  parameter int VCH_WIDTH_NUM = 2,
  parameter int VCH_NUM       = 4,
  parameter int CREDIT_DEPTH  = 4,
  parameter int CW            = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORT-1:0]               req,
  input  logic [NUM_PORT*VCH_WIDTH_NUM-1:0] req_vch,
  input  logic [NUM_PORT-1:0]               req_tail,
  input  logic [VCH_NUM-1:0]                credit_in,
  output logic [NUM_PORT-1:0]               sel,
  output logic [NUM_PORT-1:0]               ack,
  output logic [VCH_WIDTH_NUM-1:0]          lock_vch,
  output logic                              credit_err
);

  localparam int PTRW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  arb_state_e               state_q, state_d;
  logic [NUM_PORT-1:0]      sel_q, sel_d;
  logic [VCH_WIDTH_NUM-1:0] lock_q, lock_d;
  logic [PTRW-1:0]          ptr_q, ptr_d;
  logic                     err_q, err_d;
  logic [CW-1:0]            credit_q [VCH_NUM];
  logic [CW-1:0]            credit_d [VCH_NUM];

  logic [NUM_PORT-1:0]      elig;
  logic [NUM_PORT-1:0]      grant;
  logic [VCH_WIDTH_NUM-1:0] win_vch;
  logic [VCH_WIDTH_NUM-1:0] vc_i;
  logic                     lock_has_credit;
  int unsigned              owner_idx;
  logic [PTRW-1:0]          ptr_next;

  // An input is eligible only when its requested VC has at least one credit.
  always_comb begin
    elig    = '0;
    win_vch = '0;
    vc_i    = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      vc_i    = req_vch[i*VCH_WIDTH_NUM +: VCH_WIDTH_NUM];
      elig[i] = req[i] && (credit_q[vc_i] != '0);
      if (grant[i]) begin
        win_vch = win_vch | vc_i;
      end else begin
        win_vch = win_vch;
      end
    end
  end

  rr_arbiter #(
    .N  (NUM_PORT),
    .PW (PTRW)
  ) u_rr_arbiter (
    .req (elig),
    .ptr (ptr_q),
    .gnt (grant)
  );

  assign owner_idx       = oh_index(32'(sel_q));
  assign ptr_next        = (owner_idx + 32'd1 >= NUM_PORT) ? '0 : PTRW'(owner_idx + 32'd1);
  assign lock_has_credit = (credit_q[lock_q] != '0);

  // Grant FSM: arbitrate in IDLE, hold the owner until its tail flit transfers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    ack     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant != '0) begin
          sel_d   = grant;
          lock_d  = win_vch;
          state_d = ST_LOCKED;
        end else begin
          sel_d   = '0;
        end
      end
      ST_LOCKED: begin
        ack = sel_q & req & {NUM_PORT{lock_has_credit}};
        if ((ack & req_tail) != '0) begin
          sel_d   = '0;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Credit counters: a simultaneous consume and return leaves the count unchanged.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < VCH_NUM; v++) begin
      credit_d[v] = credit_q[v];
      if (credit_in[v] && !((ack != '0) && (lock_q == VCH_WIDTH_NUM'(v)))) begin
        if (credit_q[v] == CW'(CREDIT_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CW'(1);
        end
      end else if (!credit_in[v] && (ack != '0) && (lock_q == VCH_WIDTH_NUM'(v))) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end else begin
        credit_d[v] = credit_q[v];
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      lock_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int v = 0; v < VCH_NUM; v++) begin
        credit_q[v] <= CW'(CREDIT_DEPTH);
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int v = 0; v < VCH_NUM; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  assign sel        = sel_q;
  assign lock_vch   = lock_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed and randomized bench for out_port_arbiter against a packet-level reference model.
module tb_out_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req, req_tail, sel, ack;
  logic [9:0] req_vch;
  logic [3:0] credit_in;
  logic [1:0] lock_vch;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  int m_owner, m_lock, m_ptr;
  int m_cred [4];
  bit m_err;
  logic [4:0] last_ack;

  out_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_vch    (req_vch),
    .req_tail   (req_tail),
    .credit_in  (credit_in),
    .sel        (sel),
    .ack        (ack),
    .lock_vch   (lock_vch),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int vc_of(input int i);
    return int'(req_vch[i*2 +: 2]);
  endfunction

  function automatic logic [4:0] m_ack();
    if (m_owner >= 0 && req[m_owner] && m_cred[m_lock] > 0) return 5'(1 << m_owner);
    return 5'd0;
  endfunction

  function automatic logic [4:0] m_sel();
    if (m_owner >= 0) return 5'(1 << m_owner);
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_lock = 0; m_ptr = 0; m_err = 1'b0;
    for (int v = 0; v < 4; v++) m_cred[v] = 4;
  endtask

  // Packet-level rules applied at one clock edge with the inputs currently driven.
  task automatic model_step();
    logic [4:0] a;
    bit found;
    int p;
    a = m_ack();
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 5; k++) begin
        p = (m_ptr + k) % 5;
        if (!found && req[p] && m_cred[vc_of(p)] > 0) begin
          found = 1'b1; m_owner = p; m_lock = vc_of(p);
        end
      end
    end else if (a != 5'd0 && req_tail[m_owner]) begin
      m_ptr = (m_owner + 1) % 5;
      m_owner = -1;
    end
    for (int v = 0; v < 4; v++) begin
      bit d;
      d = (a != 5'd0) && (m_lock == v);
      if (credit_in[v] && !d) begin
        if (m_cred[v] == 4) m_err = 1'b1;
        else m_cred[v]++;
      end else if (d && !credit_in[v]) begin
        m_cred[v]--;
      end
    end
  endtask

  // One clock cycle: check outputs against the model, then advance both.
  task automatic cycle(input string tag);
    #2;
    last_ack = ack;
    chk({tag, ":ack"}, ack, m_ack());
    chk({tag, ":sel"}, sel, m_sel());
    if (m_owner >= 0) chk({tag, ":lock_vch"}, lock_vch, m_lock);
    chk({tag, ":credit_err"}, credit_err, m_err);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_tail = '0; req_vch = '0; credit_in = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset:sel", sel, 5'd0);
    chk("reset:ack", ack, 5'd0);
    chk("reset:lock_vch", lock_vch, 2'd0);
    chk("reset:credit_err", credit_err, 1'b0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    int order [$];
    int when [$];
    int exp_order [6];
    exp_order = '{0, 1, 2, 3, 4, 0};
    model_reset();
    last_ack = '0;

    // 3-flit packet from input 2 on VC1
    do_reset();
    req = 5'b00100; req_vch[4 +: 2] = 2'd1;
    cycle("t1_arb");
    chk("t1_sel_after_arb", sel, 5'b00100);
    n = 0;
    for (int f = 0; f < 3; f++) begin
      req_tail[2] = (f == 2);
      cycle("t1_flit");
      if (last_ack[2]) n++;
    end
    req = '0; req_tail = '0;
    chk("t1_sel_released", sel, 5'd0);
    chk("t1_ack_count", n, 3);
    req = 5'b00100;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      cycle("t1_credit1_left");
      if (last_ack[2]) n++;
    end
    chk("t1_vc1_one_credit", n, 1);

    // All inputs, single-flit packets
    do_reset();
    req = 5'b11111; req_tail = 5'b11111;
    req_vch = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int c = 0; c < 12; c++) begin
      cycle("t2_rr");
      if (last_ack != 5'd0) begin
        for (int i = 0; i < 5; i++) if (last_ack[i]) order.push_back(i);
        when.push_back(c);
      end
    end
    req = '0; req_tail = '0;
    chk("t2_grant_count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) begin
        chk("t2_grant_order", order[i], exp_order[i]);
        chk("t2_grant_cycle", when[i], 2 * i + 1);
      end
    end

    // 6-flit packet from input 1 on VC0, credit-limited
    do_reset();
    req = 5'b00010; req_vch[2 +: 2] = 2'd0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      req_tail[1] = (n == 5);
      cycle("t3_stall");
      if (last_ack[1]) n++;
    end
    chk("t3_acks_before_stall", n, 4);
    chk("t3_sel_held", sel, 5'b00010);
    for (int r = 0; r < 2; r++) begin
      credit_in = 4'b0001; req_tail[1] = (n == 5);
      cycle("t3_credit_pulse");
      if (last_ack[1]) n++;
      credit_in = 4'b0000; req_tail[1] = (n == 5);
      cycle("t3_after_credit");
      if (last_ack[1]) n++;
    end
    chk("t3_total_acks", n, 6);
    chk("t3_released", sel, 5'd0);
    req = '0; req_tail = '0;

    // Skip an input whose VC has no credit
    do_reset();
    req = 5'b00100; req_vch[4 +: 2] = 2'd2;
    n = 0;
    for (int c = 0; c < 8 && n < 4; c++) begin
      req_tail[2] = (n == 3);
      cycle("t5_drain_vc2");
      if (last_ack[2]) n++;
    end
    req = '0; req_tail = '0;
    chk("t5_drained", n, 4);
    req = 5'b10000; req_tail = 5'b10000; req_vch[8 +: 2] = 2'd0;
    cycle("t5_ptr_arb");
    cycle("t5_ptr_flit");
    req = '0; req_tail = '0;
    cycle("t5_idle");
    req = 5'b11000; req_vch[6 +: 2] = 2'd2; req_vch[8 +: 2] = 2'd3;
    cycle("t5_skip_arb");
    chk("t5_input4_granted", sel, 5'b10000);
    cycle("t5_skip_flit");
    req = '0;

    // Credit overflow and simultaneous consume/return
    do_reset();
    credit_in = 4'b0100;
    cycle("t4_overflow");
    credit_in = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      cycle("t4_sticky");
      chk("t4_err_sticky", credit_err, 1'b1);
    end
    req = 5'b00001; req_vch[0 +: 2] = 2'd1;
    cycle("t4_arb");
    credit_in = 4'b0010;
    cycle("t4_ack_and_credit");
    credit_in = 4'b0000; req_tail = 5'b00001;
    cycle("t4_tail");
    req = '0; req_tail = '0;
    cycle("t4_idle");
    req = 5'b00001;
    n = 0;
    for (int c = 0; c < 7; c++) begin
      cycle("t4_count_vc1");
      if (last_ack[0]) n++;
    end
    chk("t4_vc1_three_left", n, 3);

    // Reset in the middle of a packet
    do_reset();
    req = 5'b00100; req_vch[4 +: 2] = 2'd0;
    cycle("t6_arb");
    cycle("t6_flit");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_sel_async", sel, 5'd0);
    chk("t6_ack_async", ack, 5'd0);
    req = 5'b00101; req_vch[0 +: 2] = 2'd0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("t6_arb_after");
    chk("t6_grant_from_0", sel, 5'b00001);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      cycle("t6_credits");
      if (last_ack[0]) n++;
    end
    chk("t6_full_credits", n, 4);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req     = 5'($urandom);
      req_vch = 10'($urandom);
      for (int i = 0; i < 5; i++) req_tail[i] = ($urandom_range(0, 2) == 0);
      for (int v = 0; v < 4; v++) credit_in[v] = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
